// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: first-word-fall-through queue built on one simple dual-port SRAM.
// The SRAM registered read port is the output stage, so out_data is wired straight
// from sram_rdata and only held by not issuing a new read while the consumer stalls.
// Total capacity is depth + 1: depth entries in the array plus the one parked on
// the read port.
module sram_fifo_ctrl #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_WIDTH     = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic [SRAM_WIDTH-1:0]     push_data,
    output logic                      full,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SRAM_WIDTH-1:0]     out_data,
    output logic [SRAM_DEPTH_BIT:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    output logic [SRAM_DEPTH_BIT-1:0] sram_addr_w,
    output logic [SRAM_DEPTH_BIT-1:0] sram_addr_r,
    output logic                      sram_write_en,
    output logic                      sram_read_en,
    output logic [SRAM_WIDTH-1:0]     sram_wdata,
    input  logic [SRAM_WIDTH-1:0]     sram_rdata
);

    localparam logic [SRAM_DEPTH_BIT:0] DEPTH_CNT = (SRAM_DEPTH_BIT+1)'(1 << SRAM_DEPTH_BIT);

    logic [SRAM_DEPTH_BIT-1:0] wptr;
    logic [SRAM_DEPTH_BIT-1:0] rptr;
    logic [SRAM_DEPTH_BIT:0]   scnt;
    logic                      write_en;
    logic                      read_en;

    // Array occupancy drives full; the output slot never counts toward it, so a
    // pop while full cannot make room for a same-cycle push.
    always_comb begin
        full     = (scnt == DEPTH_CNT);
        write_en = push & ~full & ~flush;
        // Read only when something is committed in the array and the output slot
        // is empty or being drained this cycle.
        read_en  = (scnt != '0) & (~out_valid | out_ready) & ~flush;
    end

    assign sram_write_en = write_en;
    assign sram_read_en  = read_en;
    assign sram_addr_w   = wptr;
    assign sram_addr_r   = rptr;
    assign sram_wdata    = push_data;
    assign out_data      = sram_rdata;
    assign count         = scnt + {{SRAM_DEPTH_BIT{1'b0}}, out_valid};

    // Pointer, occupancy, output-slot and sticky error flag updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            scnt      <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            scnt      <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en) wptr <= wptr + 1'b1;
            if (read_en)  rptr <= rptr + 1'b1;
            case ({write_en, read_en})
                2'b10:   scnt <= scnt + 1'b1;
                2'b01:   scnt <= scnt - 1'b1;
                default: scnt <= scnt;
            endcase
            out_valid <= read_en | (out_valid & ~out_ready);
            overflow  <= overflow | (push & full);
            underflow <= underflow | (out_ready & ~out_valid);
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural SRAM model and a
// queue-based scoreboard checked by an independent output monitor.
module tb_sram_fifo_ctrl;

    localparam int DB = 2;
    localparam int W  = 28;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          push;
    logic [W-1:0]  push_data;
    logic          full;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [DB:0]   count;
    logic          overflow;
    logic          underflow;
    logic [DB-1:0] sram_addr_w;
    logic [DB-1:0] sram_addr_r;
    logic          sram_write_en;
    logic          sram_read_en;
    logic [W-1:0]  sram_wdata;
    logic [W-1:0]  sram_rdata;

    logic [W-1:0]  mem [0:(1<<DB)-1];
    logic [W-1:0]  exp_q [$];
    int            n_cmp = 0;
    int            n_bad = 0;

    sram_fifo_ctrl #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data),
        .full(full), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .overflow(overflow), .underflow(underflow),
        .sram_addr_w(sram_addr_w), .sram_addr_r(sram_addr_r),
        .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: one write port, one registered read port, no reset.
    always @(posedge clk) begin
        if (sram_write_en) mem[sram_addr_w] <= sram_wdata;
        if (sram_read_en)  sram_rdata <= mem[sram_addr_r];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the head is presented it must match the scoreboard
    // head, including stalled cycles; a pop retires the head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_data_unexpected: got 0x%0h expected none at %0t", out_data, $time);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic [W-1:0] d, input logic r);
        push = p;
        push_data = d;
        out_ready = r;
        #1;
    endtask

    task automatic flush_cycle();
        tick();
        flush = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        flush = 1'b0;
        exp_q.delete();
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push = 1'b0; push_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_full", full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_we", sram_write_en, 0);
        chk("rst_re", sram_read_en, 0);

        // Empty-to-output latency of 2 cycles.
        tick(); drive(1'b1, 28'hA, 1'b0); exp_q.push_back(28'hA);
        chk("t1_we", sram_write_en, 1); chk("t1_cnt0", count, 0);
        tick(); drive(1'b0, '0, 1'b0);
        chk("t1_re", sram_read_en, 1); chk("t1_cnt1", count, 1); chk("t1_valid_lo", out_valid, 0);
        tick(); drive(1'b0, '0, 1'b1);
        chk("t1_valid", out_valid, 1); chk("t1_cnt2", count, 1);
        tick(); drive(1'b0, '0, 1'b0);
        chk("t1_cnt3", count, 0); chk("t1_valid_end", out_valid, 0);

        // Fill to depth+1, overflow on a 6th push, then drain back-to-back.
        for (int i = 1; i <= 5; i++) begin
            tick(); drive(1'b1, W'(i), 1'b0); exp_q.push_back(W'(i));
        end
        tick(); drive(1'b1, 28'h6, 1'b0);
        chk("t2_full", full, 1); chk("t2_we_blk", sram_write_en, 0); chk("t2_cnt5", count, 5);
        tick(); drive(1'b0, '0, 1'b1);
        chk("t2_ovf", overflow, 1); chk("t2_cnt5b", count, 5); chk("t2_re", sram_read_en, 1);
        for (int k = 0; k < 5; k++) begin
            chk("t2_nobubble", out_valid, 1);
            tick(); drive(1'b0, '0, k < 4);
        end
        chk("t2_cnt_end", count, 0); chk("t2_ovf_sticky", overflow, 1);
        flush_cycle();
        chk("t2_ovf_flushed", overflow, 0);

        // Push and pop together while full: push rejected, count drops.
        for (int i = 1; i <= 5; i++) begin
            tick(); drive(1'b1, W'(28'h10 + i), 1'b0); exp_q.push_back(W'(28'h10 + i));
        end
        tick(); drive(1'b1, 28'h16, 1'b1);
        chk("t3_full", full, 1); chk("t3_we_blk", sram_write_en, 0); chk("t3_re", sram_read_en, 1);
        tick(); drive(1'b0, '0, 1'b0);
        chk("t3_cnt4", count, 4); chk("t3_ovf", overflow, 1);
        repeat (4) begin tick(); drive(1'b0, '0, 1'b1); end
        tick(); drive(1'b0, '0, 1'b0);
        chk("t3_cnt_end", count, 0);
        flush_cycle();

        // Fill, then alternate ready over 10 pushes through pointer wrap.
        // Ready-high cycles see full and reject; ready-low cycles accept.
        for (int i = 0; i < 5; i++) begin
            tick(); drive(1'b1, W'(28'h20 + i), 1'b0); exp_q.push_back(W'(28'h20 + i));
        end
        for (int k = 0; k < 10; k++) begin
            tick(); drive(1'b1, W'(28'h30 + k), (k % 2) == 0);
            if ((k % 2) == 1) exp_q.push_back(W'(28'h30 + k));
        end
        tick(); drive(1'b0, '0, 1'b1);
        chk("t4_cnt5", count, 5);
        repeat (4) begin tick(); drive(1'b0, '0, 1'b1); end
        tick(); drive(1'b0, '0, 1'b0);
        chk("t4_cnt_end", count, 0);
        flush_cycle();

        // Ready on an empty queue.
        tick(); drive(1'b0, '0, 1'b1);
        chk("t5_re", sram_read_en, 0);
        tick(); drive(1'b0, '0, 1'b0);
        chk("t5_udf", underflow, 1); chk("t5_cnt", count, 0); chk("t5_valid", out_valid, 0);

        // Flush mid-stream discards queue state and the flags.
        for (int i = 1; i <= 3; i++) begin
            tick(); drive(1'b1, W'(28'h40 + i), 1'b0); exp_q.push_back(W'(28'h40 + i));
        end
        tick(); flush = 1'b1; drive(1'b1, 28'h44, 1'b0);
        tick(); flush = 1'b0; drive(1'b0, '0, 1'b0); exp_q.delete();
        chk("t6_fl_cnt", count, 0); chk("t6_fl_valid", out_valid, 0);
        chk("t6_fl_udf", underflow, 0); chk("t6_fl_full", full, 0);

        // Async reset during a later burst.
        tick(); drive(1'b0, '0, 1'b1);
        tick(); drive(1'b1, 28'h51, 1'b0); exp_q.push_back(28'h51);
        chk("t6_udf_pre", underflow, 1);
        tick(); drive(1'b1, 28'h52, 1'b0);
        #2 rst = 1'b1; push = 1'b0; exp_q.delete();
        #1;
        chk("t6_rst_cnt", count, 0); chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_udf", underflow, 0); chk("t6_rst_re", sram_read_en, 0);
        @(posedge clk); #1 rst = 1'b0;

        // First push after reset follows the empty latency.
        tick(); drive(1'b1, 28'h7, 1'b0); exp_q.push_back(28'h7);
        chk("t7_cnt0", count, 0);
        tick(); drive(1'b0, '0, 1'b0);
        chk("t7_valid_lo", out_valid, 0); chk("t7_re", sram_read_en, 1);
        tick(); drive(1'b0, '0, 1'b1);
        chk("t7_valid", out_valid, 1);
        tick(); drive(1'b0, '0, 1'b0);
        chk("t7_cnt_end", count, 0);
        tick(); tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
